// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweep harness: walks a 4-input netlist through all 16 rows,
// samples its output after a settle time and records mismatches against TRUTH_TABLE.
module tt_sweep_checker #(
   parameter logic [15:0] TRUTH_TABLE   = 16'hC248,
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   output logic        in1,
   output logic        in2,
   output logic        in3,
   output logic        in4,
   input  logic        dut_out,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [4:0]  fail_count,
   output logic [3:0]  first_fail_row,
   output logic [15:0] mismatch_map
);

   generate
      if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
         $error("tt_sweep_checker: SETTLE_CYCLES must be in 1..255");
      end
   endgenerate

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  row_q, row_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [3:0]  drive_q, drive_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic [4:0]  fail_q, fail_d;
   logic [3:0]  ffr_q, ffr_d;
   logic [15:0] map_q, map_d;
   logic        mismatch;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         cnt_q   <= '0;
         drive_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         fail_q  <= '0;
         ffr_q   <= '0;
         map_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         cnt_q   <= cnt_d;
         drive_q <= drive_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         ffr_q   <= ffr_d;
         map_q   <= map_d;
      end
   end

   // Row r expects bit 15-r, so row 0 (all inputs low) maps to the table MSB.
   assign mismatch = dut_out != TRUTH_TABLE[4'd15 - row_q];

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      fail_d  = fail_q;
      ffr_d   = ffr_q;
      map_d   = map_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_DRIVE;
               row_d   = '0;
               cnt_d   = '0;
               pass_d  = 1'b0;
               fail_d  = '0;
               ffr_d   = '0;
               map_d   = '0;
            end
         end
         S_DRIVE: begin
            if (abort) begin
               state_d = S_IDLE;
               pass_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            if (abort) begin
               state_d = S_IDLE;
               pass_d  = 1'b0;
            end else begin
               if (mismatch) begin
                  map_d[row_q] = 1'b1;
                  if (fail_q < 5'd16) fail_d = fail_q + 5'd1;
                  if (fail_q == 5'd0) ffr_d = row_q;
               end
               if (row_q == 4'd15) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  pass_d  = (fail_d == 5'd0);
               end else begin
                  state_d = S_DRIVE;
                  row_d   = row_q + 4'd1;
                  cnt_d   = '0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Inputs and busy are registered off the next state so they line up with it.
      busy_d  = (state_d == S_DRIVE) || (state_d == S_SAMPLE);
      drive_d = busy_d ? row_d : 4'd0;
   end

   assign {in1, in2, in3, in4} = drive_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign fail_count     = fail_q;
   assign first_fail_row = ffr_q;
   assign mismatch_map   = map_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker: a table of netlist fault modes plus
// hand-written abort, mid-sweep reset and back-to-back sequences.
module tb_tt_sweep_checker;

   localparam logic [15:0] TT = 16'hC248;

   logic        clk = 1'b0;
   logic        rst_n, start, abort;
   logic        in1, in2, in3, in4;
   logic        dut_out;
   logic        busy, done, pass;
   logic [4:0]  fail_count;
   logic [3:0]  first_fail_row;
   logic [15:0] mismatch_map;

   logic [3:0]  row_in;
   logic        gold;
   int          mode;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   tt_sweep_checker #(.TRUTH_TABLE(TT), .SETTLE_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .in1(in1), .in2(in2), .in3(in3), .in4(in4), .dut_out(dut_out),
      .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
      .first_fail_row(first_fail_row), .mismatch_map(mismatch_map)
   );

   // Netlist stand-in: golden 0xC248 function or one of several faulty variants.
   always_comb begin
      row_in  = {in1, in2, in3, in4};
      gold    = TT[4'd15 - row_in];
      dut_out = gold;
      case (mode)
         1: dut_out = 1'b0;
         2: dut_out = 1'b1;
         3: dut_out = ~gold;
         4: dut_out = gold ^ ((row_in == 4'd5) || (row_in == 4'd11));
         default: dut_out = gold;
      endcase
   end

   typedef struct {
      int          mode;
      int          mid_start;
      logic        exp_pass;
      logic [4:0]  exp_fc;
      logic [15:0] exp_map;
      logic [3:0]  exp_ffr;
   } vec_t;

   vec_t vecs[5];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_pass"}, 32'(pass), 32'd0);
      check({tag, "_fc"},   32'(fail_count), 32'd0);
      check({tag, "_ffr"},  32'(first_fail_row), 32'd0);
      check({tag, "_map"},  32'(mismatch_map), 32'd0);
      check({tag, "_in"},   32'(row_in), 32'd0);
   endtask

   // Pulses start, then follows the sweep until busy drops; returns in the done cycle.
   task automatic run_sweep(input int mid_start);
      int bc;
      bit seq_ok;
      start = 1'b1;
      tick();
      start = 1'b0;
      bc = 0;
      seq_ok = 1'b1;
      while (busy && bc < 200) begin
         if (row_in != 4'(bc / 5)) seq_ok = 1'b0;
         start = (mid_start != 0) && (bc == mid_start);
         tick();
         bc++;
      end
      start = 1'b0;
      check("input_sequence", 32'(seq_ok), 32'd1);
      check("busy_cycles", 32'(bc), 32'd80);
      check("done_pulse", 32'(done), 32'd1);
   endtask

   initial begin
      vecs[0] = '{0, 0,  1'b1, 5'd0,  16'h0000, 4'd0};
      vecs[1] = '{1, 30, 1'b0, 5'd5,  16'h1243, 4'd0};
      vecs[2] = '{2, 0,  1'b0, 5'd11, 16'hEDBC, 4'd2};
      vecs[3] = '{3, 47, 1'b0, 5'd16, 16'hFFFF, 4'd0};
      vecs[4] = '{4, 0,  1'b0, 5'd2,  16'h0820, 4'd5};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 0;
      tick();
      tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick();
      check("idle_in", 32'(row_in), 32'd0);

      for (int i = 0; i < 5; i++) begin
         mode = vecs[i].mode;
         run_sweep(vecs[i].mid_start);
         check("pass",  32'(pass), 32'(vecs[i].exp_pass));
         check("fail_count", 32'(fail_count), 32'(vecs[i].exp_fc));
         check("mismatch_map", 32'(mismatch_map), 32'(vecs[i].exp_map));
         check("first_fail_row", 32'(first_fail_row), 32'(vecs[i].exp_ffr));
         tick();
         check("done_one_cycle", 32'(done), 32'd0);
         check("done_in_zero", 32'(row_in), 32'd0);
         check("pass_hold", 32'(pass), 32'(vecs[i].exp_pass));
      end

      // Back-to-back: second start lands in the done cycle of the first sweep.
      mode = 0;
      run_sweep(0);
      check("b2b_first_pass", 32'(pass), 32'd1);
      mode = 1;
      run_sweep(0);
      check("b2b_fc", 32'(fail_count), 32'd5);
      check("b2b_map", 32'(mismatch_map), 32'h1243);
      tick();

      // Abort during row 7 with output stuck low: rows 0,1,6 already failed.
      mode = 1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 200 && row_in != 4'd7; k++) tick();
      check("reach_row7", 32'(row_in), 32'd7);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_in", 32'(row_in), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_pass", 32'(pass), 32'd0);
      check("abort_fc", 32'(fail_count), 32'd3);
      check("abort_map", 32'(mismatch_map), 32'h0043);
      begin
         bit quiet = 1'b1;
         for (int k = 0; k < 4; k++) begin
            tick();
            if (done || busy) quiet = 1'b0;
         end
         check("abort_quiet", 32'(quiet), 32'd1);
      end
      mode = 0;
      run_sweep(0);
      check("post_abort_pass", 32'(pass), 32'd1);
      check("post_abort_map", 32'(mismatch_map), 32'h0000);
      tick();

      // One-cycle reset in the middle of row 10.
      mode = 1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 200 && row_in != 4'd10; k++) tick();
      check("reach_row10", 32'(row_in), 32'd10);
      tick();
      check("pre_reset_fc", 32'(fail_count), 32'd4);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_reset_outputs("midreset");
      tick();
      check("midreset_stays_idle", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
